// File: rtl/wallace_pkg.sv
// Shared widths and product type for the 8x8 Wallace multiplier datapath.
package wallace_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 2*OP_W;
  localparam int SPLIT  = OP_W;
  typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/wallace_final_adder_rca_slice.sv
// Ripple-carry adder slice built from a chain of full_adder cells.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module rca_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);
  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < W; g++) begin : g_fa
    full_adder u_fa (
      .i_a   (i_a[g]),
      .i_b   (i_b[g]),
      .i_cin (w_c[g]),
      .o_s   (o_s[g]),
      .o_cout(w_c[g+1])
    );
  end

  assign o_cout = w_c[W];
endmodule

// File: rtl/wallace_final_adder.sv
// Two-stage pipelined carry-propagate adder (low half, then high half) closing
// the Wallace tree, with valid/ready handshakes on both sides.
module wallace_final_adder
  import wallace_pkg::*;
#(
  parameter int PROD_W = wallace_pkg::PROD_W,
  parameter int SPLIT  = wallace_pkg::SPLIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              err_carry_out
);
  localparam int HI_W = PROD_W - SPLIT;

  logic              r_s1_valid;
  logic [SPLIT-1:0]  r_lo;
  logic              r_cmid;
  logic [HI_W-1:0]   r_sum_hi;
  logic [HI_W-1:0]   r_carry_hi;
  logic              r_s2_valid;
  logic [PROD_W-1:0] r_prod;
  logic              r_err;

  logic [SPLIT-1:0]  w_lo;
  logic              w_cmid;
  logic [HI_W-1:0]   w_hi;
  logic              w_ctop;
  logic              w_s2_adv;
  logic              w_in_acc;

  rca_slice #(.W(SPLIT)) u_lo (
    .i_a   (in_sum[SPLIT-1:0]),
    .i_b   (in_carry[SPLIT-1:0]),
    .i_cin (1'b0),
    .o_s   (w_lo),
    .o_cout(w_cmid)
  );

  // High half adds the registered upper rows plus the carry handed over from stage 1.
  rca_slice #(.W(HI_W)) u_hi (
    .i_a   (r_sum_hi),
    .i_b   (r_carry_hi),
    .i_cin (r_cmid),
    .o_s   (w_hi),
    .o_cout(w_ctop)
  );

  assign w_s2_adv = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_in_acc = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_cmid     <= 1'b0;
      r_sum_hi   <= '0;
      r_carry_hi <= '0;
      r_s2_valid <= 1'b0;
      r_prod     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_in_acc) begin
        r_lo       <= w_lo;
        r_cmid     <= w_cmid;
        r_sum_hi   <= in_sum[PROD_W-1:SPLIT];
        r_carry_hi <= in_carry[PROD_W-1:SPLIT];
      end
      if (w_s2_adv) r_prod <= {w_hi, r_lo};
      // Sticky: a legal tree output never carries past the MSB.
      if (w_s2_adv && w_ctop) r_err <= 1'b1;
      r_s1_valid <= w_in_acc | (r_s1_valid & ~w_s2_adv);
      r_s2_valid <= w_s2_adv | (r_s2_valid & ~out_ready);
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_product   = r_prod;
  assign err_carry_out = r_err;
endmodule

// File: tb/tb_wallace_final_adder.sv
// Scoreboard bench for wallace_final_adder: expected products queued on accept, checked on output transfer.
module tb_wallace_final_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sum = '0;
  logic [15:0] in_carry = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic        err_carry_out;

  int          errs = 0;
  int          checks = 0;
  int          n_out = 0;
  logic [15:0] cur_exp = '0;
  logic [15:0] q[$];

  wallace_final_adder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .err_carry_out(err_carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Carry-save reduction of the partial products, kept wide so rows never truncate.
  task automatic tree(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] s, output logic [15:0] c);
    logic [31:0] ws, wc, pp, ns;
    ws = '0;
    wc = '0;
    for (int i = 0; i < 8; i++) begin
      pp = b[i] ? ({24'b0, a} << i) : 32'd0;
      ns = ws ^ wc ^ pp;
      wc = ((ws & wc) | (ws & pp) | (wc & pp)) << 1;
      ws = ns;
    end
    s = ws[15:0];
    c = wc[15:0];
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic send(input logic [15:0] s, input logic [15:0] c, input logic [15:0] e);
    logic acc;
    int   n;
    in_sum   = s;
    in_carry = c;
    cur_exp  = e;
    in_valid = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("unexpected_out", {16'b0, out_product}, 32'hDEAD_0000);
        else chk("product", out_product, q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] s, c, held;
    logic [7:0]  a, b;
    int          base;

    // reset state
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", out_product, 0);
    chk("rst_err", err_carry_out, 0);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    // basic + latency
    out_ready = 1'b1;
    send(16'hFE00, 16'h0001, 16'hFE01);
    chk("lat_edge1_valid", out_valid, 0);
    step();
    chk("lat_edge2_valid", out_valid, 1);
    chk("basic_product", out_product, 16'hFE01);
    chk("basic_err", err_carry_out, 0);
    drain();

    // carry across the split
    send(16'h00FF, 16'h0001, 16'h0100);
    send(16'h7F80, 16'h0080, 16'h8000);
    drain();

    // backpressure
    out_ready = 1'b0;
    send(16'h0102, 16'h0001, 16'h0103);
    send(16'h1000, 16'h0234, 16'h1234);
    in_sum = 16'h00F0; in_carry = 16'h0010; cur_exp = 16'h0100; in_valid = 1'b1;
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    held = out_product;
    chk("bp_head", held, 16'h0103);
    step();
    step();
    chk("bp_stable", out_product, held);
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_second", out_product, 16'h1234);
    drain();

    // streaming legal tree outputs
    base = n_out;
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (k == 0) begin a = 8'hFF; b = 8'hFF; end
      tree(a, b, s, c);
      in_sum = s; in_carry = c; cur_exp = 16'(a * b);
      if (!in_ready) chk("stream_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_count", n_out - base, 256);
    chk("stream_err", err_carry_out, 0);
    drain();

    // overflow sticky
    send(16'hFFFF, 16'h0001, 16'h0000);
    step();
    chk("ovf_err", err_carry_out, 1);
    send(16'h0001, 16'h0002, 16'h0003);
    drain();
    step();
    chk("ovf_err_sticky", err_carry_out, 1);

    // reset with two pairs in flight
    out_ready = 1'b0;
    send(16'h1111, 16'h0001, 16'h1112);
    send(16'h2222, 16'h0002, 16'h2224);
    chk("pre_rst_full", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err", err_carry_out, 0);
    chk("mid_rst_product", out_product, 0);
    q.delete();
    step();
    rst = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_no_stale", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
